// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, load/store port, memory port and stall/err flags.
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store,
// data-first with alternation on contention, req/ack handshake with timeout. Rev 1.0
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_DATA  = 2'd1;
  localparam logic [1:0] c_FETCH = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  // Last count value still waiting; no ack on that cycle means 2**TMO_W-1 cycles elapsed.
  localparam int              c_TMO_LAST_I = (1 << TMO_W) - 2;
  localparam logic [TMO_W-1:0] c_TMO_LAST  = c_TMO_LAST_I[TMO_W-1:0];
  localparam logic [TMO_W-1:0] c_CNT_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [TMO_W-1:0]  r_cnt;
  logic              r_grant_data;
  logic              r_last_was_data;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ready;
  logic              r_dm_ready;
  logic              r_err;

  logic w_dm_pend;
  logic w_pick_data;
  logic w_tmo;

  assign w_dm_pend   = bus.dm_read | bus.dm_write;
  assign w_pick_data = w_dm_pend & (~bus.if_req | ~r_last_was_data);
  assign w_tmo       = (r_cnt == c_TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= c_IDLE;
      r_cnt           <= '0;
      r_grant_data    <= 1'b0;
      r_last_was_data <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_if_rdata      <= '0;
      r_dm_rdata      <= '0;
      r_if_ready      <= 1'b0;
      r_dm_ready      <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_dm_pend || bus.if_req) begin
            r_mem_req <= 1'b1;
            r_cnt     <= '0;
            if (w_pick_data) begin
              // A simultaneous read+write is served as a write and flagged.
              r_grant_data <= 1'b1;
              r_mem_we     <= bus.dm_write;
              r_mem_addr   <= bus.dm_addr;
              r_mem_wdata  <= bus.dm_wdata;
              r_state      <= c_DATA;
              if (bus.dm_read && bus.dm_write) r_err <= 1'b1;
            end else begin
              r_grant_data <= 1'b0;
              r_mem_we     <= 1'b0;
              r_mem_addr   <= bus.if_addr;
              r_state      <= c_FETCH;
            end
          end
        end
        c_DATA, c_FETCH: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= c_RESP;
            if (r_grant_data) begin
              r_dm_ready <= 1'b1;
              if (!r_mem_we) r_dm_rdata <= bus.mem_rdata;
            end else begin
              r_if_ready <= 1'b1;
              r_if_rdata <= bus.mem_rdata;
            end
          end else if (w_tmo) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= c_RESP;
            if (r_grant_data) begin
              r_dm_ready <= 1'b1;
              r_dm_rdata <= '0;
            end else begin
              r_if_ready <= 1'b1;
              r_if_rdata <= '0;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_RESP: begin
          r_last_was_data <= r_grant_data;
          r_cnt           <= '0;
          r_state         <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_ready  = r_dm_ready;
  assign bus.err       = r_err;
  assign bus.stall_if  = bus.if_req & ~r_if_ready;
  assign bus.stall_mem = w_dm_pend & ~r_dm_ready;

endmodule

`default_nettype wire
